hazard_ctrl_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It computes
//  the EX-stage operand forwarding selects (rs, rt) and the store-data forwarding select.
//  It enforces a load-use stall whose length is programmable, and freezes the pipeline on a

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/fwd_select.sv | 34 +++
 rtl/hazard_ctrl_unit.sv | 182 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: forwarding select encoding and hazard FSM states.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   typedef enum logic [1:0] {
      HZ_RUN  = 2'd0,
      HZ_LU   = 2'd1,
      HZ_MEMW = 2'd2
   } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding source selection for one register operand.
// EX/MEM wins over MEM/WB. A load in EX/MEM has no data yet, so it is skipped.
module fwd_select
   import cpu_types_pkg::*;
#(
   parameter int unsigned REG_W  = 5,
   parameter int unsigned FWD_WB = 1
) (
   input  logic             en,
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] exmem_wsel,
   input  logic             exmem_regwr,
   input  logic             exmem_dren,
   input  logic [REG_W-1:0] memwb_wsel,
   input  logic             memwb_regwr,
   output logic [1:0]       sel
);

   logic src_nz;
   assign src_nz = (src != '0);

   // Priority compare of the operand against the two younger writers.
   always_comb begin
      sel = FWD_NONE;
      if (en && src_nz) begin
         if (exmem_regwr && (exmem_wsel == src) && !exmem_dren) begin
            sel = FWD_EXMEM;
         end else if ((FWD_WB != 0) && memwb_regwr && (memwb_wsel == src)) begin
            sel = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand/store
// forwarding selects, programmable load-use stall, data-memory freeze, and
// branch flush. Drives every pipeline latch enable and flush.
module hazard_ctrl_unit
   import cpu_types_pkg::*;
#(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned LU_STALL = 1,
   parameter int unsigned FWD_WB   = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_use_rt,
   input  logic [REG_W-1:0] idex_rs,
   input  logic [REG_W-1:0] idex_rt,
   input  logic [REG_W-1:0] idex_wsel,
   input  logic             idex_regwr,
   input  logic             idex_dren,
   input  logic             idex_dwen,
   input  logic [REG_W-1:0] exmem_wsel,
   input  logic             exmem_regwr,
   input  logic             exmem_dren,
   input  logic             exmem_dwen,
   input  logic             dhit,
   input  logic             ihit,
   input  logic [REG_W-1:0] memwb_wsel,
   input  logic             memwb_regwr,
   input  logic             br_taken,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       fwd_sw,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             hz_busy
);

   localparam logic [1:0] LU_INIT = 2'(LU_STALL);

   hz_state_t  state_q, state_d;
   hz_state_t  ret_q, ret_d;
   hz_state_t  eff_state;
   logic [1:0] lu_cnt_q, lu_cnt_d;
   logic [1:0] lu_eff;
   logic       lu_hit, lu_active, mem_wait;
   logic [1:0] sel_a, sel_b, sel_sw;

   // A load always writes its destination; the write flag adds nothing here.
   logic unused_idex_regwr;
   assign unused_idex_regwr = idex_regwr;

   fwd_select #(.REG_W(REG_W), .FWD_WB(FWD_WB)) u_fwd_rs (
      .en          (1'b1),
      .src         (idex_rs),
      .exmem_wsel  (exmem_wsel),
      .exmem_regwr (exmem_regwr),
      .exmem_dren  (exmem_dren),
      .memwb_wsel  (memwb_wsel),
      .memwb_regwr (memwb_regwr),
      .sel         (sel_a)
   );

   fwd_select #(.REG_W(REG_W), .FWD_WB(FWD_WB)) u_fwd_rt (
      .en          (1'b1),
      .src         (idex_rt),
      .exmem_wsel  (exmem_wsel),
      .exmem_regwr (exmem_regwr),
      .exmem_dren  (exmem_dren),
      .memwb_wsel  (memwb_wsel),
      .memwb_regwr (memwb_regwr),
      .sel         (sel_b)
   );

   fwd_select #(.REG_W(REG_W), .FWD_WB(FWD_WB)) u_fwd_sw (
      .en          (idex_dwen),
      .src         (idex_rt),
      .exmem_wsel  (exmem_wsel),
      .exmem_regwr (exmem_regwr),
      .exmem_dren  (exmem_dren),
      .memwb_wsel  (memwb_wsel),
      .memwb_regwr (memwb_regwr),
      .sel         (sel_sw)
   );

   // Hazard detection; HZ_MEMW behaves as the state it interrupted.
   always_comb begin
      eff_state = (state_q == HZ_MEMW) ? ret_q : state_q;
      mem_wait  = (exmem_dren || exmem_dwen) && !dhit;
      lu_hit    = idex_dren && (idex_wsel != '0) &&
                  ((idex_wsel == ifid_rs) || (ifid_use_rt && (idex_wsel == ifid_rt)));
      lu_active = (eff_state == HZ_LU) || lu_hit;
      // The detection cycle is itself the first bubble, so it consumes one count.
      lu_eff    = (eff_state == HZ_LU) ? lu_cnt_q : LU_INIT;
   end

   // Next state: mem wait > branch > load-use > run.
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      lu_cnt_d = lu_cnt_q;
      if (mem_wait) begin
         state_d = HZ_MEMW;
         ret_d   = eff_state;
      end else if (br_taken) begin
         state_d  = HZ_RUN;
         ret_d    = HZ_RUN;
         lu_cnt_d = '0;
      end else if (lu_active) begin
         ret_d = HZ_RUN;
         if (lu_eff <= 2'd1) begin
            state_d  = HZ_RUN;
            lu_cnt_d = '0;
         end else begin
            state_d  = HZ_LU;
            lu_cnt_d = lu_eff - 2'd1;
         end
      end else begin
         state_d  = HZ_RUN;
         ret_d    = HZ_RUN;
         lu_cnt_d = '0;
      end
   end

   // FSM, return state and stall counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= HZ_RUN;
         ret_q    <= HZ_RUN;
         lu_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         lu_cnt_q <= lu_cnt_d;
      end
   end

   // Latch controls; everything is forced low while reset is asserted.
   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      hz_busy    = 1'b0;
      fwd_a      = FWD_NONE;
      fwd_b      = FWD_NONE;
      fwd_sw     = FWD_NONE;
      if (nRST) begin
         fwd_a   = sel_a;
         fwd_b   = sel_b;
         fwd_sw  = sel_sw;
         hz_busy = (state_q != HZ_RUN);
         if (!mem_wait) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (br_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (lu_active) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end else if (!ihit) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one instance with a 2-cycle load-use
// stall and WB forwarding, one with a 1-cycle stall and no WB forwarding.
module tb_hazard_ctrl_unit;

   logic       CLK = 1'b0;
   logic       nRST;
   logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_wsel, exmem_wsel, memwb_wsel;
   logic       ifid_use_rt, idex_regwr, idex_dren, idex_dwen;
   logic       exmem_regwr, exmem_dren, exmem_dwen, dhit, ihit, memwb_regwr, br_taken;

   logic [1:0] fwd_a, fwd_b, fwd_sw;
   logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, hz_busy;
   logic [1:0] fwd_a_2, fwd_b_2, fwd_sw_2;
   logic       pc_en_2, ifid_en_2, ifid_flush_2, idex_en_2, idex_flush_2;
   logic       exmem_en_2, memwb_en_2, hz_busy_2;

   logic [7:0] ctl, ctl_2;
   int         total = 0;
   int         bad   = 0;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, hz_busy}
   assign ctl   = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, hz_busy};
   assign ctl_2 = {pc_en_2, ifid_en_2, ifid_flush_2, idex_en_2, idex_flush_2,
                   exmem_en_2, memwb_en_2, hz_busy_2};

   localparam logic [7:0] C_RUN   = 8'hD6;
   localparam logic [7:0] C_LU0   = 8'h1E;  // stall, state still HZ_RUN
   localparam logic [7:0] C_LU1   = 8'h1F;  // stall, busy
   localparam logic [7:0] C_FRZ0  = 8'h00;
   localparam logic [7:0] C_FRZ1  = 8'h01;
   localparam logic [7:0] C_BR0   = 8'hFE;
   localparam logic [7:0] C_BR1   = 8'hFF;
   localparam logic [7:0] C_IMISS = 8'h76;

   always #5 CLK = ~CLK;

   hazard_ctrl_unit #(.REG_W(5), .LU_STALL(2), .FWD_WB(1)) u_dut (
      .CLK(CLK), .nRST(nRST),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wsel(idex_wsel),
      .idex_regwr(idex_regwr), .idex_dren(idex_dren), .idex_dwen(idex_dwen),
      .exmem_wsel(exmem_wsel), .exmem_regwr(exmem_regwr), .exmem_dren(exmem_dren),
      .exmem_dwen(exmem_dwen), .dhit(dhit), .ihit(ihit),
      .memwb_wsel(memwb_wsel), .memwb_regwr(memwb_regwr), .br_taken(br_taken),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_sw(fwd_sw),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .hz_busy(hz_busy)
   );

   hazard_ctrl_unit #(.REG_W(5), .LU_STALL(1), .FWD_WB(0)) u_dut_2 (
      .CLK(CLK), .nRST(nRST),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wsel(idex_wsel),
      .idex_regwr(idex_regwr), .idex_dren(idex_dren), .idex_dwen(idex_dwen),
      .exmem_wsel(exmem_wsel), .exmem_regwr(exmem_regwr), .exmem_dren(exmem_dren),
      .exmem_dwen(exmem_dwen), .dhit(dhit), .ihit(ihit),
      .memwb_wsel(memwb_wsel), .memwb_regwr(memwb_regwr), .br_taken(br_taken),
      .fwd_a(fwd_a_2), .fwd_b(fwd_b_2), .fwd_sw(fwd_sw_2),
      .pc_en(pc_en_2), .ifid_en(ifid_en_2), .ifid_flush(ifid_flush_2),
      .idex_en(idex_en_2), .idex_flush(idex_flush_2),
      .exmem_en(exmem_en_2), .memwb_en(memwb_en_2), .hz_busy(hz_busy_2)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      ifid_rs = '0; ifid_rt = '0; ifid_use_rt = 1'b0;
      idex_rs = '0; idex_rt = '0; idex_wsel = '0;
      idex_regwr = 1'b0; idex_dren = 1'b0; idex_dwen = 1'b0;
      exmem_wsel = '0; exmem_regwr = 1'b0; exmem_dren = 1'b0; exmem_dwen = 1'b0;
      memwb_wsel = '0; memwb_regwr = 1'b0;
      dhit = 1'b1; ihit = 1'b1; br_taken = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge, checks 1 unit later.
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_use();
      idex_dren = 1'b1; idex_regwr = 1'b1; idex_wsel = 5'd5; ifid_rs = 5'd5;
   endtask

   task automatic load_to_mem();
      idex_dren = 1'b0; idex_regwr = 1'b0; idex_wsel = '0;
      exmem_wsel = 5'd5; exmem_regwr = 1'b1; exmem_dren = 1'b1;
   endtask

   initial begin
      nRST = 1'b0;
      clr();
      #2;
      chk("reset_ctl", ctl, C_FRZ0);
      chk("reset_fwd", {2'b0, fwd_a, fwd_b, fwd_sw}, 8'h00);

      cyc(); nRST = 1'b1; #1;
      chk("idle_ctl", ctl, C_RUN);

      // Forwarding: EX/MEM beats MEM/WB; $0 never forwards.
      cyc(); idex_rs = 5'd3; idex_rt = 5'd3; exmem_wsel = 5'd3; exmem_regwr = 1'b1;
      memwb_wsel = 5'd3; memwb_regwr = 1'b1; #1;
      chk("fwd_a_exmem", {6'b0, fwd_a}, 8'd1);
      chk("fwd_b_exmem", {6'b0, fwd_b}, 8'd1);
      chk("fwd_a_exmem_nowb", {6'b0, fwd_a_2}, 8'd1);
      idex_rs = 5'd0; #1;
      chk("fwd_a_r0", {6'b0, fwd_a}, 8'd0);
      idex_rs = 5'd3; exmem_dren = 1'b1; #1;
      chk("fwd_a_load_in_mem", {6'b0, fwd_a}, 8'd2);

      cyc(); clr(); memwb_wsel = 5'd7; memwb_regwr = 1'b1; idex_rt = 5'd7; #1;
      chk("fwd_b_memwb", {6'b0, fwd_b}, 8'd2);
      chk("fwd_b_nowb", {6'b0, fwd_b_2}, 8'd0);
      chk("fwd_sw_no_store", {6'b0, fwd_sw}, 8'd0);
      idex_dwen = 1'b1; #1;
      chk("fwd_sw_memwb", {6'b0, fwd_sw}, 8'd2);
      chk("fwd_sw_nowb", {6'b0, fwd_sw_2}, 8'd0);

      // Load-use with a 2-bubble stall; add then picks the load up from MEM/WB.
      cyc(); clr(); load_use(); #1;
      chk("lu_detect", ctl, C_LU0);
      chk("lu_detect_2", ctl_2, C_LU0);
      cyc(); idex_dren = 1'b0; idex_regwr = 1'b0; idex_wsel = '0;
      exmem_wsel = 5'd5; exmem_regwr = 1'b1; #1;
      chk("lu_second", ctl, C_LU1);
      chk("lu_done_2", ctl_2, C_RUN);
      cyc(); clr(); idex_rs = 5'd5; memwb_wsel = 5'd5; memwb_regwr = 1'b1; #1;
      chk("lu_exit", ctl, C_RUN);
      chk("lu_fwd_a", {6'b0, fwd_a}, 8'd2);

      // Data-memory wait in the middle of the load-use stall.
      cyc(); clr(); load_use(); #1;
      chk("mw_detect", ctl, C_LU0);
      cyc(); load_to_mem(); dhit = 1'b0; #1;
      chk("mw_freeze0", ctl, C_FRZ1);
      chk("mw_freeze0_2", ctl_2, C_FRZ0);
      for (int i = 1; i < 4; i++) begin
         cyc(); #1;
         chk($sformatf("mw_freeze%0d", i), ctl, C_FRZ1);
      end
      cyc(); dhit = 1'b1; #1;
      chk("mw_resume", ctl, C_LU1);
      chk("mw_resume_2", ctl_2, 8'hD7);
      cyc(); clr(); #1;
      chk("mw_after", ctl, C_RUN);

      // Branch beats a pending load-use, and cancels one already stalling.
      cyc(); clr(); load_use(); br_taken = 1'b1; #1;
      chk("br_over_lu", ctl, C_BR0);
      cyc(); clr(); #1;
      chk("br_next_run", ctl, C_RUN);
      cyc(); load_use(); #1;
      chk("br_lu_detect", ctl, C_LU0);
      cyc(); clr(); ifid_rs = 5'd5; br_taken = 1'b1; #1;
      chk("br_in_lu", ctl, C_BR1);
      cyc(); clr(); #1;
      chk("br_cancel_lu", ctl, C_RUN);

      // Fetch miss, and load-use taking priority over it.
      cyc(); clr(); ihit = 1'b0; #1;
      chk("imiss", ctl, C_IMISS);
      load_use(); #1;
      chk("lu_over_imiss", ctl, C_LU0);
      cyc(); clr(); #1;
      chk("lu_imiss_second", ctl, C_LU1);

      // Reset in the middle of a stall.
      cyc(); clr(); load_use(); #1;
      chk("rst_lu_detect", ctl, C_LU0);
      cyc(); idex_dren = 1'b0; idex_regwr = 1'b0; idex_wsel = '0; #1;
      chk("rst_lu_second", ctl, C_LU1);
      #1 nRST = 1'b0; idex_rs = 5'd3; exmem_wsel = 5'd3; exmem_regwr = 1'b1; #1;
      chk("rst_mid_ctl", ctl, C_FRZ0);
      chk("rst_mid_fwd", {6'b0, fwd_a}, 8'd0);
      cyc(); #1;
      chk("rst_held", ctl, C_FRZ0);
      #1 nRST = 1'b1; clr(); #1;
      chk("rst_release", ctl, C_RUN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
